prefetch_stream_buffer: RTL and testbench
=========================================

// Module: prefetch_stream_buffer
// PURPOSE
//  Next-line stream prefetch buffer for the set-associative L1 cache.
//  - Sits directly upstream of the cache: consulted on every cache lookup miss;
//    its prefetch_hit output feeds the cache's prefetch_hit input.
//  - Holds ENTRIES prefetched block addresses.
//  - Refills with sequential next-line addresses after each lookup.
// PARAMETERS
//  ENTRIES    4   buffer depth, power of 2, >=2
//  ADDR_W     28  block-address width (32 - log2(block_size_byte))
//  DEGREE     2   next-line blocks inserted on a buffer miss, 1..ENTRIES
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  lookup_valid   in   1       lookup request (cache miss, block address valid)
//  lookup_addr    in   ADDR_W  block address {tag,index}
//  lookup_ready   out  1       high only in IDLE; request accepted when valid&&ready
//  resp_valid     out  1       one-cycle pulse: prefetch_hit is updated
//  prefetch_hit   out  1       lookup result; held until next accepted lookup
//  occupancy      out  log2(ENTRIES)+1  number of valid entries
//  pf_insert_cnt  out  20      total addresses inserted (saturates at 2^20-1)
// BEHAVIOUR
//  Reset (async): all entries invalid, write ptr=0, state=IDLE, lookup_ready=1,
//    resp_valid=0, prefetch_hit=0, occupancy=0, pf_insert_cnt=0.
//  FSM: IDLE -> SEARCH -> FILL -> IDLE.
//   IDLE: lookup_ready=1; on accept (cycle T) register lookup_addr -> SEARCH.
//   SEARCH (T+1): parallel compare against all valid entries.
//     At T+2: resp_valid=1 for one cycle; prefetch_hit=1 iff any entry matched.
//     Matching entry is invalidated in the same cycle.
//   FILL: one candidate per cycle, issued in order.
//     Buffer hit: 1 candidate, A+DEGREE.
//     Buffer miss: DEGREE candidates, A+1 .. A+DEGREE.
//     Returns to IDLE after the last candidate; lookup_ready is back at 1 in
//     cycle T+3+n, where n = number of candidates.
//  Insert rules:
//   - Candidate already valid in buffer: skipped; not counted; still takes its cycle.
//   - Free slot exists: lowest-index invalid slot is written.
//   - Buffer full: slot at write ptr (FIFO-oldest) is overwritten; ptr += 1 mod ENTRIES.
//   - Each insert increments pf_insert_cnt, saturating.
//  Address arithmetic: modulo 2^ADDR_W; e.g. all-ones + 1 = 0, no carry-out.
//  occupancy: valid-entry count, updated the cycle after any insert or invalidate.
//    Never exceeds ENTRIES.
//  Flow control: lookup_valid outside IDLE is ignored. The requester must hold
//    lookup_valid until the handshake completes.
//  A lookup hitting and inserting in the same sequence: the invalidate (SEARCH)
//    always precedes the inserts (FILL).
//  Reset mid-SEARCH/FILL: the operation is aborted and no resp_valid is issued.
// CONFIGURATION
//  PF_FLUSH_ON_MISS_EN defined:
//    - On a buffer miss, all entries are invalidated at T+2 (with resp).
//    - Write ptr is cleared to 0 before FILL; the stream restarts from A.
//  PF_FLUSH_ON_MISS_EN undefined:
//    - No flush; old entries are retained and aged out by FIFO replacement only.
// TESTING
//  1. Reset, lookup A=0x10 -> resp at T+2, prefetch_hit=0; 0x11, 0x12 inserted;
//     occupancy=2; pf_insert_cnt=2.
//  2. After 1, lookup 0x11 -> prefetch_hit=1; 0x11 invalidated; 0x13 inserted;
//     occupancy=2; lookup_ready high at T+4.
//  3. Fill to 4 entries (0x11..0x14, no flush), lookup 0x40 -> 0x41 and 0x42
//     overwrite FIFO-oldest two; occupancy=4.
//  4. Lookup 0x0FFFFFFF -> inserts 0x0000000 and 0x0000001 (wrap); a repeated
//     lookup skips duplicates, pf_insert_cnt unchanged.
//  5. Assert rst during FILL -> outputs at reset values immediately;
//     occupancy=0; no resp_valid follows.
//  6. PF_FLUSH_ON_MISS_EN: 3 valid entries, buffer-miss lookup 0x80 -> only
//     0x81, 0x82 remain valid; occupancy=2.

Source files
------------

// File: rtl/prefetch_stream_buffer.sv
// Next-line stream prefetch buffer consulted on every L1 lookup miss; prefetch_hit feeds the cache.
// Latency: resp_valid pulses at T+2 after accept at T; lookup_ready returns at T+3+n (n = fill candidates).
// Backpressure: lookup_ready is high only in IDLE; lookup_valid outside IDLE is ignored.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   lookup_valid/addr/ready  lookup request handshake (block address {tag,index})
//   resp_valid               one-cycle pulse when prefetch_hit is updated
//   prefetch_hit             lookup result, held until the next accepted lookup
//   occupancy                number of valid entries
//   pf_insert_cnt            saturating count of inserted addresses
//
// Optional feature macro: PF_FLUSH_ON_MISS_EN -- a buffer miss flushes all
// entries (with the response) and restarts the stream from the missing address.

module prefetch_stream_buffer #(
  parameter int ENTRIES = 4,
  parameter int ADDR_W  = 28,
  parameter int DEGREE  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lookup_valid,
  input  logic [ADDR_W-1:0]          lookup_addr,
  output logic                       lookup_ready,
  output logic                       resp_valid,
  output logic                       prefetch_hit,
  output logic [$clog2(ENTRIES):0]   occupancy,
  output logic [19:0]                pf_insert_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int OCC_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    FILL   = 2'd2
  } state_t;

  state_t              state;
  logic                resolve;      // second SEARCH cycle: response is visible, invalidate committed
  logic [ADDR_W-1:0]   req_addr;
  logic [ADDR_W-1:0]   cand_addr;    // next candidate to insert
  logic [OCC_W-1:0]    cand_left;    // candidates still to issue, including cand_addr
  logic [ENTRIES-1:0]  entry_valid;
  logic [ADDR_W-1:0]   entry_addr [ENTRIES];
  logic [IDX_W-1:0]    wptr;         // FIFO-oldest slot, advanced only on overwrite

  logic [ENTRIES-1:0]  match_vec;
  logic                any_match;
  logic                cand_dup;
  logic                free_found;
  logic [IDX_W-1:0]    free_idx;
  logic                ins_en;
  logic                ins_overwrite;
  logic [IDX_W-1:0]    ins_idx;
  logic [ENTRIES-1:0]  valid_next;
  logic [OCC_W-1:0]    occ_next;

  // Parallel compares: request address for SEARCH, candidate address for FILL.
  always_comb begin
    match_vec  = '0;
    cand_dup   = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match_vec[i] = entry_valid[i] && (entry_addr[i] == req_addr);
      if (entry_valid[i] && (entry_addr[i] == cand_addr)) cand_dup = 1'b1;
    end
    // Walk downwards so the lowest-index free slot wins.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!entry_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign any_match = |match_vec;

  // Next valid vector; occupancy is registered from it so it tracks the array exactly.
  always_comb begin
    valid_next    = entry_valid;
    ins_en        = 1'b0;
    ins_overwrite = 1'b0;
    ins_idx       = wptr;
    occ_next      = '0;
    case (state)
      SEARCH: begin
        if (!resolve) begin
`ifdef PF_FLUSH_ON_MISS_EN
          if (any_match) valid_next = entry_valid & ~match_vec;
          else           valid_next = '0;
`else
          valid_next = entry_valid & ~match_vec;
`endif
        end
      end
      FILL: begin
        // A candidate already present is skipped but still consumes its cycle.
        if (!cand_dup) begin
          ins_en = 1'b1;
          if (free_found) begin
            ins_idx = free_idx;
          end else begin
            ins_idx       = wptr;
            ins_overwrite = 1'b1;
          end
          valid_next[ins_idx] = 1'b1;
        end
      end
      default: ;
    endcase
    for (int i = 0; i < ENTRIES; i++) begin
      occ_next = occ_next + OCC_W'(valid_next[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      resolve       <= 1'b0;
      req_addr      <= '0;
      cand_addr     <= '0;
      cand_left     <= '0;
      entry_valid   <= '0;
      wptr          <= '0;
      lookup_ready  <= 1'b1;
      resp_valid    <= 1'b0;
      prefetch_hit  <= 1'b0;
      occupancy     <= '0;
      pf_insert_cnt <= '0;
    end else begin
      entry_valid <= valid_next;
      occupancy   <= occ_next;
      resp_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (lookup_valid && lookup_ready) begin
            req_addr     <= lookup_addr;
            resolve      <= 1'b0;
            lookup_ready <= 1'b0;
            state        <= SEARCH;
          end
        end
        SEARCH: begin
          if (!resolve) begin
            resp_valid   <= 1'b1;
            prefetch_hit <= any_match;
            resolve      <= 1'b1;
            if (any_match) begin
              // Stream confirmed: extend it by one block beyond the lookahead.
              cand_addr <= req_addr + ADDR_W'(DEGREE);
              cand_left <= OCC_W'(1);
            end else begin
              cand_addr <= req_addr + ADDR_W'(1);
              cand_left <= OCC_W'(DEGREE);
`ifdef PF_FLUSH_ON_MISS_EN
              wptr      <= '0;
`endif
            end
          end else begin
            state <= FILL;
          end
        end
        FILL: begin
          if (ins_en) begin
            if (ins_overwrite) wptr <= wptr + IDX_W'(1);
            if (pf_insert_cnt != 20'hFFFFF) pf_insert_cnt <= pf_insert_cnt + 20'd1;
          end
          cand_addr <= cand_addr + ADDR_W'(1);
          cand_left <= cand_left - OCC_W'(1);
          if (cand_left == OCC_W'(1)) begin
            state        <= IDLE;
            lookup_ready <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          lookup_ready <= 1'b1;
        end
      endcase
    end
  end

  // Address storage needs no reset: entries are qualified by entry_valid.
  always_ff @(posedge clk) begin
    if (state == FILL && ins_en) entry_addr[ins_idx] <= cand_addr;
  end

endmodule

// File: tb/tb_prefetch_stream_buffer.sv
module tb_prefetch_stream_buffer;

  localparam int ENTRIES = 4;
  localparam int ADDR_W  = 28;
  localparam int DEGREE  = 2;
`ifdef PF_FLUSH_ON_MISS_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              lookup_valid = 1'b0;
  logic [ADDR_W-1:0] lookup_addr = '0;
  logic              lookup_ready;
  logic              resp_valid;
  logic              prefetch_hit;
  logic [2:0]        occupancy;
  logic [19:0]       pf_insert_cnt;

  int vecs = 0;
  int miscompares = 0;

  typedef struct {
    bit hit;
    int n;
    int occ;
    int cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  bit                m_valid [ENTRIES];
  logic [ADDR_W-1:0] m_addr  [ENTRIES];
  int                m_wptr = 0;
  int                m_cnt  = 0;

  prefetch_stream_buffer #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .DEGREE(DEGREE)) dut (
    .clk           (clk),
    .rst           (rst),
    .lookup_valid  (lookup_valid),
    .lookup_addr   (lookup_addr),
    .lookup_ready  (lookup_ready),
    .resp_valid    (resp_valid),
    .prefetch_hit  (prefetch_hit),
    .occupancy     (occupancy),
    .pf_insert_cnt (pf_insert_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vecs, miscompares);
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_wptr = 0;
    m_cnt  = 0;
  endtask

  // Whole-lookup reference: result, candidate count and post-fill state.
  task automatic model_lookup(input logic [ADDR_W-1:0] a, output exp_t e);
    int hit_i;
    int occ;
    logic [ADDR_W-1:0] c;
    hit_i = -1;
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_addr[i] == a) hit_i = i;
    e.hit = (hit_i >= 0);
    if (e.hit) begin
      m_valid[hit_i] = 1'b0;
      e.n = 1;
      c = a + ADDR_W'(DEGREE);
    end else begin
      if (FLUSH) begin
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        m_wptr = 0;
      end
      e.n = DEGREE;
      c = a + ADDR_W'(1);
    end
    for (int k = 0; k < e.n; k++) begin
      bit dup;
      int slot;
      dup  = 1'b0;
      slot = -1;
      for (int i = 0; i < ENTRIES; i++)
        if (m_valid[i] && m_addr[i] == c) dup = 1'b1;
      if (!dup) begin
        for (int i = ENTRIES - 1; i >= 0; i--)
          if (!m_valid[i]) slot = i;
        if (slot < 0) begin
          slot   = m_wptr;
          m_wptr = (m_wptr + 1) % ENTRIES;
        end
        m_valid[slot] = 1'b1;
        m_addr[slot]  = c;
        if (m_cnt < 20'hFFFFF) m_cnt++;
      end
      c = c + ADDR_W'(1);
    end
    occ = 0;
    for (int i = 0; i < ENTRIES; i++) occ += m_valid[i] ? 1 : 0;
    e.occ = occ;
    e.cnt = m_cnt;
  endtask

  // Called at a negedge; returns at the negedge where lookup_ready is back.
  task automatic do_lookup(input logic [ADDR_W-1:0] a);
    exp_t e;
    exp_t got;
    bit   have;
    bit   done;
    int   k;
    int   t;
    model_lookup(a, e);
    sb.push_back(e);
    lookup_valid = 1'b1;
    lookup_addr  = a;
    t = 0;
    while (!lookup_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    vecs++;
    if (!lookup_ready) begin
      miscompares++;
      $display("FAIL accept_timeout addr=%h: lookup_ready=%b, required 1", a, lookup_ready);
      lookup_valid = 1'b0;
      void'(sb.pop_back());
      return;
    end
    @(posedge clk);
    #1;
    // Keep valid asserted with a different address while busy: it must be ignored.
    lookup_addr = a ^ 28'h5A5A5A5;
    have = 1'b0;
    done = 1'b0;
    k = 0;
    got = '{hit: 1'b0, n: 0, occ: 0, cnt: 0};
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
      if (resp_valid) begin
        vecs++;
        if (have || sb.size() == 0) begin
          miscompares++;
          $display("FAIL resp_extra addr=%h: resp_valid=1 at cycle T+%0d, required no further response", a, k);
        end else begin
          got  = sb.pop_front();
          have = 1'b1;
          if (k != 2) begin
            miscompares++;
            $display("FAIL resp_latency addr=%h: resp at T+%0d, required T+2", a, k);
          end
          vecs++;
          if (prefetch_hit !== got.hit) begin
            miscompares++;
            $display("FAIL resp_hit addr=%h: prefetch_hit=%b, required %b", a, prefetch_hit, got.hit);
          end
        end
      end
      if (lookup_ready) begin
        done = 1'b1;
        lookup_valid = 1'b0;
        vecs++;
        if (!have) begin
          miscompares++;
          $display("FAIL resp_missing addr=%h: lookup_ready at T+%0d with no resp_valid", a, k);
          if (sb.size() != 0) got = sb.pop_front();
        end
        vecs++;
        if (k != 3 + got.n) begin
          miscompares++;
          $display("FAIL ready_latency addr=%h: ready at T+%0d, required T+%0d", a, k, 3 + got.n);
        end
        vecs++;
        if (occupancy !== 3'(got.occ)) begin
          miscompares++;
          $display("FAIL occupancy addr=%h: got %0d, required %0d", a, occupancy, got.occ);
        end
        vecs++;
        if (pf_insert_cnt !== 20'(got.cnt)) begin
          miscompares++;
          $display("FAIL insert_cnt addr=%h: got %0d, required %0d", a, pf_insert_cnt, got.cnt);
        end
        vecs++;
        if (prefetch_hit !== got.hit) begin
          miscompares++;
          $display("FAIL hit_hold addr=%h: prefetch_hit=%b, required %b", a, prefetch_hit, got.hit);
        end
      end
    end
    if (!done) begin
      vecs++;
      miscompares++;
      lookup_valid = 1'b0;
      $display("FAIL ready_timeout addr=%h: lookup_ready not back within 20 cycles", a);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_outputs(input string tag);
    vecs++;
    if (lookup_ready !== 1'b1 || resp_valid !== 1'b0 || prefetch_hit !== 1'b0 ||
        occupancy !== 3'd0 || pf_insert_cnt !== 20'd0) begin
      miscompares++;
      $display("FAIL %s: ready=%b resp=%b hit=%b occ=%0d cnt=%0d, required 1 0 0 0 0",
               tag, lookup_ready, resp_valid, prefetch_hit, occupancy, pf_insert_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_held");
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs("reset_released");
  endtask

  task automatic test_miss_insert();
    do_lookup(28'h10);
    vecs++;
    if (occupancy !== 3'd2 || pf_insert_cnt !== 20'd2 || prefetch_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL miss_insert: occ=%0d cnt=%0d hit=%b, required 2 2 0", occupancy, pf_insert_cnt, prefetch_hit);
    end
  endtask

  task automatic test_hit();
    do_lookup(28'h11);
    vecs++;
    if (prefetch_hit !== 1'b1 || occupancy !== 3'd2 || pf_insert_cnt !== 20'd3) begin
      miscompares++;
      $display("FAIL hit: hit=%b occ=%0d cnt=%0d, required 1 2 3", prefetch_hit, occupancy, pf_insert_cnt);
    end
  endtask

  task automatic test_fifo_replace();
    apply_reset();
    do_lookup(28'h12);
    do_lookup(28'h10);
    vecs++;
    if (occupancy !== (FLUSH ? 3'd2 : 3'd4)) begin
      miscompares++;
      $display("FAIL fill_four: occ=%0d, required %0d", occupancy, FLUSH ? 2 : 4);
    end
    do_lookup(28'h40);
    vecs++;
    if (occupancy !== (FLUSH ? 3'd2 : 3'd4)) begin
      miscompares++;
      $display("FAIL replace_occ: occ=%0d, required %0d", occupancy, FLUSH ? 2 : 4);
    end
    do_lookup(28'h41);
    do_lookup(28'h13);
    vecs++;
    if (prefetch_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL evicted_oldest: hit=%b for 0x13, required 0", prefetch_hit);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    do_lookup(28'hFFFFFFF);
    vecs++;
    if (pf_insert_cnt !== 20'd2) begin
      miscompares++;
      $display("FAIL wrap_insert: cnt=%0d, required 2", pf_insert_cnt);
    end
    do_lookup(28'hFFFFFFF);
    vecs++;
    if (pf_insert_cnt !== (FLUSH ? 20'd4 : 20'd2)) begin
      miscompares++;
      $display("FAIL dup_skip: cnt=%0d, required %0d", pf_insert_cnt, FLUSH ? 4 : 2);
    end
    do_lookup(28'h0);
    vecs++;
    if (prefetch_hit !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_hit: hit=%b for 0x0, required 1", prefetch_hit);
    end
  endtask

  task automatic test_reset_mid_op();
    for (int s = 0; s < 2; s++) begin
      int depth;
      bit seen_resp;
      depth = (s == 0) ? 1 : 4;  // mid-SEARCH, then mid-FILL after one insert
      lookup_valid = 1'b1;
      lookup_addr  = 28'h200;
      @(posedge clk);
      #1;
      lookup_valid = 1'b0;
      repeat (depth) @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_outputs(s == 0 ? "reset_mid_search" : "reset_mid_fill");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      seen_resp = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (resp_valid) seen_resp = 1'b1;
      end
      vecs++;
      if (seen_resp || lookup_ready !== 1'b1 || occupancy !== 3'd0) begin
        miscompares++;
        $display("FAIL abort_quiet depth=%0d: resp_seen=%b ready=%b occ=%0d, required 0 1 0",
                 depth, seen_resp, lookup_ready, occupancy);
      end
    end
  endtask

  task automatic test_flush();
    apply_reset();
    do_lookup(28'h10);
    do_lookup(28'h11);
    do_lookup(28'h80);
    vecs++;
    if (occupancy !== (FLUSH ? 3'd2 : 3'd4)) begin
      miscompares++;
      $display("FAIL flush_occ: occ=%0d, required %0d", occupancy, FLUSH ? 2 : 4);
    end
    do_lookup(28'h12);
    vecs++;
    if (prefetch_hit !== (FLUSH ? 1'b0 : 1'b1)) begin
      miscompares++;
      $display("FAIL flush_old_entry: hit=%b for 0x12, required %b", prefetch_hit, !FLUSH);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      logic [ADDR_W-1:0] a;
      a = 28'h100 + 28'($urandom_range(0, 11));
      do_lookup(a);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_miss_insert();
    test_hit();
    test_fifo_replace();
    test_wrap();
    test_reset_mid_op();
    test_flush();
    test_back_to_back();
    vecs++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expected responses never seen, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
